// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared widths, forwarding-select encoding and a forwarding helper for the
// 5-stage pipeline hazard controller.
package hazard_pkg;

  localparam int NREG     = 16;
  localparam int NSRC     = 3;
  localparam int MAX_MC   = 4;
  localparam int BR_DRAIN = 3;
  localparam int RW       = $clog2(NREG);
  localparam int OW       = $clog2(MAX_MC + 1);
  localparam int DW       = $clog2(BR_DRAIN + 1);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // The M stage holds the younger result, so it wins over W on a double match.
  function automatic fwd_sel_t fwd_pick(input logic          vld,
                                        input logic [RW-1:0] rs,
                                        input logic          wr_m,
                                        input logic [RW-1:0] rd_m,
                                        input logic          wr_w,
                                        input logic [RW-1:0] rd_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (vld && wr_m && (rd_m == rs))      sel = FWD_M;
    else if (vld && wr_w && (rd_w == rs)) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// Pipeline-to-hazard-unit bundle: per-stage register info in, stall/flush/forward
// controls out. The pipeline side is the master, the hazard controller the slave.
interface hazard_ctrl_sb_if;
  import hazard_pkg::*;

  logic [NSRC*RW-1:0] rs_d;
  logic [NSRC-1:0]    rs_vld_d;
  logic [NSRC*RW-1:0] rs_e;
  logic [NSRC-1:0]    rs_vld_e;
  logic [RW-1:0]      rd_e;
  logic [RW-1:0]      rd_m;
  logic [RW-1:0]      rd_w;
  logic               regwrite_e;
  logic               regwrite_m;
  logic               regwrite_w;
  logic               memtoreg_e;
  logic               pcwr_d;
  logic               branch_taken_e;
  logic               mc_issue;
  logic [RW-1:0]      mc_rd;
  logic               mc_done;
  logic [RW-1:0]      mc_done_rd;

  logic [NSRC*2-1:0]  fwd_sel_e;
  logic               stall_f;
  logic               stall_d;
  logic               flush_d;
  logic               flush_e;
  logic [OW-1:0]      mc_outstanding;
  logic               sb_err;

  modport master (
    output rs_d, rs_vld_d, rs_e, rs_vld_e, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, pcwr_d,
           branch_taken_e, mc_issue, mc_rd, mc_done, mc_done_rd,
    input  fwd_sel_e, stall_f, stall_d, flush_d, flush_e, mc_outstanding, sb_err
  );

  modport slave (
    input  rs_d, rs_vld_d, rs_e, rs_vld_e, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, pcwr_d,
           branch_taken_e, mc_issue, mc_rd, mc_done, mc_done_rd,
    output fwd_sel_e, stall_f, stall_d, flush_d, flush_e, mc_outstanding, sb_err
  );

endinterface

// File: rtl/hazard_ctrl_sb_scoreboard.sv
// Per-register pending scoreboard for multi-cycle ops (div/vector): tracks which
// destinations are still in flight, how many, and flags protocol misuse stickily.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_issue,
  input  logic [RW-1:0]      i_issue_rd,
  input  logic               i_done,
  input  logic [RW-1:0]      i_done_rd,
  input  logic [NSRC*RW-1:0] i_rs,
  input  logic [NSRC-1:0]    i_rs_vld,
  output logic [NSRC-1:0]    o_rs_pending,
  output logic [OW-1:0]      o_count,
  output logic               o_full,
  output logic               o_err
);

  logic [NREG-1:0] r_pending;
  logic [OW-1:0]   r_count;
  logic            r_err;

  logic            w_done_ok;
  logic            w_handoff;
  logic            w_issue_ok;
  logic            w_proto_err;
  logic [NREG-1:0] w_pending_nxt;

  // A done that retires a slot in the same cycle frees room for a new issue, and a
  // done+issue on the same register is a hand-off rather than a double booking.
  assign w_done_ok   = i_done & r_pending[i_done_rd];
  assign w_handoff   = w_done_ok & (i_done_rd == i_issue_rd);
  assign o_full      = (r_count == OW'(MAX_MC));
  assign w_issue_ok  = i_issue & (~r_pending[i_issue_rd] | w_handoff)
                               & (~o_full | w_done_ok);
  assign w_proto_err = (i_done & ~w_done_ok) | (i_issue & ~w_issue_ok);

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_done_ok)  w_pending_nxt[i_done_rd]  = 1'b0;
    if (w_issue_ok) w_pending_nxt[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= r_count + OW'(w_issue_ok) - OW'(w_done_ok);
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_lookup
    assign o_rs_pending[g] = i_rs_vld[g] & r_pending[i_rs[g*RW +: RW]];
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller for the F/D/E/M/W core: operand forwarding, load-use and
// scoreboard stalls, and the PC-write drain that holds fetch until the PC settles.
module hazard_ctrl_sb
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_sb_if.slave  hz_if
);

  logic [NSRC-1:0]   w_rs_pending;
  logic [OW-1:0]     w_count;
  logic              w_sb_full;
  logic              w_sb_err;
  logic [NSRC-1:0]   w_ld_match;
  logic              w_ld_stall;
  logic              w_sb_stall;
  logic              w_stall_d;
  logic [NSRC*2-1:0] w_fwd_sel;
  logic [DW-1:0]     r_drain;

  hazard_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue      (hz_if.mc_issue),
    .i_issue_rd   (hz_if.mc_rd),
    .i_done       (hz_if.mc_done),
    .i_done_rd    (hz_if.mc_done_rd),
    .i_rs         (hz_if.rs_d),
    .i_rs_vld     (hz_if.rs_vld_d),
    .o_rs_pending (w_rs_pending),
    .o_count      (w_count),
    .o_full       (w_sb_full),
    .o_err        (w_sb_err)
  );

  always_comb begin
    w_fwd_sel  = '0;
    w_ld_match = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_fwd_sel[2*i +: 2] = fwd_pick(hz_if.rs_vld_e[i], hz_if.rs_e[i*RW +: RW],
                                     hz_if.regwrite_m, hz_if.rd_m,
                                     hz_if.regwrite_w, hz_if.rd_w);
      w_ld_match[i] = hz_if.rs_vld_d[i] & (hz_if.rs_d[i*RW +: RW] == hz_if.rd_e);
    end
  end

  // A taken branch redirects fetch, so it overrides every hold on F and D.
  assign w_ld_stall = hz_if.memtoreg_e & hz_if.regwrite_e & (|w_ld_match);
  assign w_sb_stall = (|w_rs_pending) | (w_sb_full & hz_if.mc_issue);
  assign w_stall_d  = (w_ld_stall | w_sb_stall) & ~hz_if.branch_taken_e;

  // Drain runs freely once armed; only a redirect or reset can cut it short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain <= '0;
    end else if (hz_if.branch_taken_e) begin
      r_drain <= '0;
    end else if (hz_if.pcwr_d && !w_stall_d) begin
      r_drain <= DW'(BR_DRAIN);
    end else if (r_drain != '0) begin
      r_drain <= r_drain - DW'(1);
    end
  end

  assign hz_if.fwd_sel_e      = w_fwd_sel;
  assign hz_if.stall_d        = w_stall_d;
  assign hz_if.stall_f        = ~hz_if.branch_taken_e
                                & (w_stall_d | hz_if.pcwr_d | (r_drain > DW'(1)));
  assign hz_if.flush_d        = hz_if.pcwr_d | (r_drain != '0) | hz_if.branch_taken_e;
  assign hz_if.flush_e        = w_ld_stall | w_sb_stall | hz_if.branch_taken_e;
  assign hz_if.mc_outstanding = w_count;
  assign hz_if.sb_err         = w_sb_err;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: directed scenarios plus randomized traffic
// checked against a register-array reference model of the hazard rules.
module tb_hazard_ctrl_sb;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_sb_if u_if ();

  hazard_ctrl_sb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (u_if.slave)
  );

  int checks = 0;
  int errors = 0;

  bit m_pend [NREG];
  int m_drain = 0;
  bit m_err   = 1'b0;

  function automatic int pend_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic bit ld_stall();
    bit hit = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (u_if.rs_vld_d[i] && u_if.rs_d[i*RW +: RW] == u_if.rd_e) hit = 1'b1;
    return u_if.memtoreg_e && u_if.regwrite_e && hit;
  endfunction

  function automatic bit sb_stall();
    bit hit = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (u_if.rs_vld_d[i] && m_pend[u_if.rs_d[i*RW +: RW]]) hit = 1'b1;
    return hit || (pend_count() == MAX_MC && u_if.mc_issue);
  endfunction

  function automatic bit exp_stall_d();
    return (ld_stall() || sb_stall()) && !u_if.branch_taken_e;
  endfunction

  function automatic logic [NSRC*2-1:0] exp_fwd();
    logic [NSRC*2-1:0] v = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (u_if.rs_vld_e[i] && u_if.regwrite_m && u_if.rd_m == u_if.rs_e[i*RW +: RW])
        v[2*i +: 2] = 2'b10;
      else if (u_if.rs_vld_e[i] && u_if.regwrite_w && u_if.rd_w == u_if.rs_e[i*RW +: RW])
        v[2*i +: 2] = 2'b01;
    end
    return v;
  endfunction

  function automatic logic [NSRC*2+OW+4:0] exp_vec();
    bit bt = u_if.branch_taken_e;
    bit sf = !bt && (exp_stall_d() || u_if.pcwr_d || m_drain > 1);
    bit fd = u_if.pcwr_d || m_drain != 0 || bt;
    bit fe = ld_stall() || sb_stall() || bt;
    return {exp_fwd(), sf, exp_stall_d(), fd, fe, OW'(pend_count()), m_err};
  endfunction

  function automatic logic [NSRC*2+OW+4:0] dut_vec();
    return {u_if.fwd_sel_e, u_if.stall_f, u_if.stall_d, u_if.flush_d, u_if.flush_e,
            u_if.mc_outstanding, u_if.sb_err};
  endfunction

  task automatic model_step();
    bit sd      = exp_stall_d();
    bit done_ok = u_if.mc_done && m_pend[u_if.mc_done_rd];
    bit issue_ok = 1'b0;
    if (u_if.mc_done && !done_ok) m_err = 1'b1;
    if (u_if.mc_issue) begin
      bit busy = m_pend[u_if.mc_rd] && !(done_ok && u_if.mc_done_rd == u_if.mc_rd);
      int left = pend_count() - int'(done_ok);
      if (busy || left >= MAX_MC) m_err = 1'b1;
      else issue_ok = 1'b1;
    end
    if (done_ok)  m_pend[u_if.mc_done_rd] = 1'b0;
    if (issue_ok) m_pend[u_if.mc_rd] = 1'b1;
    if (u_if.branch_taken_e)            m_drain = 0;
    else if (u_if.pcwr_d && !sd)        m_drain = BR_DRAIN;
    else if (m_drain > 0)               m_drain = m_drain - 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
      m_drain = 0;
      m_err   = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic clear_inputs();
    u_if.rs_d = '0; u_if.rs_vld_d = '0; u_if.rs_e = '0; u_if.rs_vld_e = '0;
    u_if.rd_e = '0; u_if.rd_m = '0; u_if.rd_w = '0;
    u_if.regwrite_e = 1'b0; u_if.regwrite_m = 1'b0; u_if.regwrite_w = 1'b0;
    u_if.memtoreg_e = 1'b0; u_if.pcwr_d = 1'b0; u_if.branch_taken_e = 1'b0;
    u_if.mc_issue = 1'b0; u_if.mc_rd = '0; u_if.mc_done = 1'b0; u_if.mc_done_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", dut_vec());
    end
    checks++;
    if (u_if.mc_outstanding !== '0) begin
      errors++;
      $display("[TB] FAIL reset_count got %0d want 0", u_if.mc_outstanding);
    end
    tick();
  endtask

  task automatic test_forwarding();
    u_if.rs_e[0 +: RW] = 4'd5; u_if.rs_e[RW +: RW] = 4'd5; u_if.rs_vld_e = 3'b011;
    u_if.rd_m = 4'd5; u_if.rd_w = 4'd5; u_if.regwrite_m = 1'b1; u_if.regwrite_w = 1'b1;
    #1;
    checks++;
    if (u_if.fwd_sel_e !== 6'b00_10_10) begin
      errors++;
      $display("[TB] FAIL fwd_m_priority got %b want 001010", u_if.fwd_sel_e);
    end
    u_if.regwrite_m = 1'b0;
    #1;
    checks++;
    if (u_if.fwd_sel_e !== 6'b00_01_01) begin
      errors++;
      $display("[TB] FAIL fwd_w_only got %b want 000101", u_if.fwd_sel_e);
    end
    for (int n = 0; n < 30; n++) begin
      u_if.rs_e = NSRC*RW'($urandom); u_if.rs_vld_e = NSRC'($urandom);
      u_if.rd_m = RW'($urandom_range(3)); u_if.rd_w = RW'($urandom_range(3));
      for (int i = 0; i < NSRC; i++) u_if.rs_e[i*RW +: RW] = RW'($urandom_range(3));
      u_if.regwrite_m = 1'($urandom); u_if.regwrite_w = 1'($urandom);
      #1;
      checks++;
      if (u_if.fwd_sel_e !== exp_fwd()) begin
        errors++;
        $display("[TB] FAIL fwd_random got %b want %b", u_if.fwd_sel_e, exp_fwd());
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    u_if.memtoreg_e = 1'b1; u_if.regwrite_e = 1'b1; u_if.rd_e = 4'd3;
    u_if.rs_d[RW +: RW] = 4'd3; u_if.rs_vld_d = 3'b010;
    #1;
    checks++;
    if ({u_if.stall_f, u_if.stall_d, u_if.flush_e} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL load_use_stall got %b want 111",
               {u_if.stall_f, u_if.stall_d, u_if.flush_e});
    end
    tick();
    u_if.memtoreg_e = 1'b0; u_if.regwrite_e = 1'b0;
    #1;
    checks++;
    if ({u_if.stall_f, u_if.stall_d, u_if.flush_e} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL load_use_release got %b want 000",
               {u_if.stall_f, u_if.stall_d, u_if.flush_e});
    end
    u_if.memtoreg_e = 1'b1; u_if.regwrite_e = 1'b1; u_if.rs_vld_d = 3'b000;
    #1;
    checks++;
    if (u_if.stall_d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_invalid_src got %b want 0", u_if.stall_d);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mc_stall();
    u_if.mc_issue = 1'b1; u_if.mc_rd = 4'd7;
    tick();
    u_if.mc_issue = 1'b0; u_if.rs_d[0 +: RW] = 4'd7; u_if.rs_vld_d = 3'b001;
    #1;
    checks++;
    if (u_if.mc_outstanding !== 3'd1) begin
      errors++;
      $display("[TB] FAIL mc_count_one got %0d want 1", u_if.mc_outstanding);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin u_if.mc_done = 1'b1; u_if.mc_done_rd = 4'd7; end
      #1;
      checks++;
      if (u_if.stall_d !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mc_stall_hold cycle %0d got %b want 1", c, u_if.stall_d);
      end
      tick();
    end
    u_if.mc_done = 1'b0;
    #1;
    checks++;
    if ({u_if.stall_d, u_if.mc_outstanding} !== 4'b0_000) begin
      errors++;
      $display("[TB] FAIL mc_stall_release got %b want 0000",
               {u_if.stall_d, u_if.mc_outstanding});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mc_full();
    apply_reset();
    for (int r = 1; r <= 4; r++) begin
      u_if.mc_issue = 1'b1; u_if.mc_rd = RW'(r);
      tick();
    end
    u_if.mc_issue = 1'b0;
    #1;
    checks++;
    if (u_if.mc_outstanding !== 3'd4) begin
      errors++;
      $display("[TB] FAIL mc_full_count got %0d want 4", u_if.mc_outstanding);
    end
    u_if.mc_issue = 1'b1; u_if.mc_rd = 4'd5;
    #1;
    checks++;
    if ({u_if.stall_d, u_if.flush_e} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL mc_full_stall got %b want 11", {u_if.stall_d, u_if.flush_e});
    end
    tick();
    u_if.mc_issue = 1'b1; u_if.mc_rd = 4'd2; u_if.mc_done = 1'b1; u_if.mc_done_rd = 4'd2;
    tick();
    clear_inputs();
    u_if.rs_d[2*RW +: RW] = 4'd2; u_if.rs_vld_d = 3'b100;
    #1;
    checks++;
    if ({u_if.stall_d, u_if.mc_outstanding} !== {1'b1, 3'd4}) begin
      errors++;
      $display("[TB] FAIL mc_handoff got %b want 1100", {u_if.stall_d, u_if.mc_outstanding});
    end
    checks++;
    if (u_if.sb_err !== m_err) begin
      errors++;
      $display("[TB] FAIL mc_full_err got %b want %b", u_if.sb_err, m_err);
    end
    apply_reset();
  endtask

  task automatic test_drain();
    int nf = 0;
    int nd = 0;
    for (int c = 0; c < 6; c++) begin
      u_if.pcwr_d = (c == 0);
      #1;
      nf += int'(u_if.stall_f);
      nd += int'(u_if.flush_d);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL drain_cycle %0d got %h want %h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (nf != 3 || nd != 4) begin
      errors++;
      $display("[TB] FAIL drain_lengths got stall_f=%0d flush_d=%0d want 3/4", nf, nd);
    end
  endtask

  task automatic test_branch_mid_drain();
    u_if.pcwr_d = 1'b1;
    tick();
    u_if.pcwr_d = 1'b0;
    tick();
    u_if.branch_taken_e = 1'b1;
    u_if.memtoreg_e = 1'b1; u_if.regwrite_e = 1'b1; u_if.rd_e = 4'd6;
    u_if.rs_d[0 +: RW] = 4'd6; u_if.rs_vld_d = 3'b001;
    #1;
    checks++;
    if ({u_if.stall_f, u_if.stall_d, u_if.flush_d, u_if.flush_e} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL branch_redirect got %b want 0011",
               {u_if.stall_f, u_if.stall_d, u_if.flush_d, u_if.flush_e});
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({u_if.stall_f, u_if.flush_d} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL branch_drain_cleared got %b want 00", {u_if.stall_f, u_if.flush_d});
    end
    tick();
  endtask

  task automatic test_err_and_async_reset();
    apply_reset();
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 4'd9;
    tick();
    u_if.mc_done = 1'b0;
    tick();
    tick();
    checks++;
    if (u_if.sb_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_err_sticky got %b want 1", u_if.sb_err);
    end
    u_if.mc_issue = 1'b1; u_if.mc_rd = 4'd4;
    tick();
    u_if.mc_rd = 4'd6;
    tick();
    u_if.mc_issue = 1'b0; u_if.pcwr_d = 1'b1;
    tick();
    u_if.pcwr_d = 1'b0;
    tick();
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h want 0", dut_vec());
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      for (int i = 0; i < NSRC; i++) begin
        u_if.rs_d[i*RW +: RW] = RW'($urandom_range(7));
        u_if.rs_e[i*RW +: RW] = RW'($urandom_range(7));
      end
      u_if.rs_vld_d = NSRC'($urandom); u_if.rs_vld_e = NSRC'($urandom);
      u_if.rd_e = RW'($urandom_range(7)); u_if.rd_m = RW'($urandom_range(7));
      u_if.rd_w = RW'($urandom_range(7));
      u_if.regwrite_e = 1'($urandom); u_if.regwrite_m = 1'($urandom);
      u_if.regwrite_w = 1'($urandom); u_if.memtoreg_e = ($urandom_range(3) == 0);
      u_if.pcwr_d = ($urandom_range(7) == 0); u_if.branch_taken_e = ($urandom_range(7) == 0);
      u_if.mc_issue = ($urandom_range(2) == 0); u_if.mc_rd = RW'($urandom_range(7));
      u_if.mc_done = ($urandom_range(2) == 0); u_if.mc_done_rd = RW'($urandom_range(7));
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_cycle %0d got %h want %h", n, dut_vec(), exp_vec());
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_stall();
    test_mc_full();
    test_drain();
    test_branch_mid_drain();
    test_err_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
